// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C register target.
// State encoding, bus acknowledge levels and byte width.
package i2c_tgt_pkg;

    localparam int BYTE_W = 8;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_MACK,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer plus majority-free glitch filter for one I2C line.
// The filtered level moves only after FILT_LEN equal synchronized samples; rise/fall pulse with the change.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILT_LEN-2:0]    hist_q;
    logic [SYNC_STAGES:0]   syncChain;
    logic [FILT_LEN-1:0]    window;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   goHigh;
    logic                   goLow;

    assign syncChain = {sync_q, line_i};
    assign window    = {hist_q, sync_q[SYNC_STAGES-1]};
    assign goHigh    = (&window) & ~level_q;
    assign goLow     = ~(|window) & level_q;

    // Idle bus is high, so everything resets high to avoid a false edge after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '1;
            hist_q  <= '1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= syncChain[SYNC_STAGES-1:0];
            hist_q <= window[FILT_LEN-2:0];
            rise_q <= goHigh;
            fall_q <= goLow;
            if (goHigh) begin
                level_q <= 1'b1;
            end else if (goLow) begin
                level_q <= 1'b0;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8-bit register pointer and an external byte register port.
// Oversamples SCL/SDA, never stretches SCL, drives SDA open-drain through oSDA_OE.
module i2c_target_regs
    import i2c_tgt_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h39,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              I2C_SCLK,
    input  logic              I2C_SDAT_IN,
    output logic              oSDA_OE,
    output logic [BYTE_W-1:0] oREG_ADDR,
    output logic [BYTE_W-1:0] oREG_WDATA,
    output logic              oREG_WE,
    input  logic [BYTE_W-1:0] iREG_RDATA,
    output logic              oBUSY,
    output logic              oSTOP
);

    localparam logic [3:0] CNT_FULL = 4'(BYTE_W);

    logic sclLevel, sclRise, sclFall;
    logic sdaLevel, sdaRise, sdaFall;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sclFilt (
        .clk_i  (iCLK),
        .rst_ni (iRST_N),
        .line_i (I2C_SCLK),
        .level_o(sclLevel),
        .rise_o (sclRise),
        .fall_o (sclFall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sdaFilt (
        .clk_i  (iCLK),
        .rst_ni (iRST_N),
        .line_i (I2C_SDAT_IN),
        .level_o(sdaLevel),
        .rise_o (sdaRise),
        .fall_o (sdaFall)
    );

    state_e            state_q, state_d;
    logic [3:0]        bitCnt_q, bitCnt_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [BYTE_W-1:0] ptr_q, ptr_d;
    logic [BYTE_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              stop_q, stop_d;
    logic              rw_q, rw_d;

    logic              sclWasHigh;
    logic              startDet;
    logic              stopDet;
    logic              byteDone;
    logic [BYTE_W-1:0] rxByte;

    // SCL level before this cycle, so an SDA edge coinciding with an SCL edge still classifies correctly.
    assign sclWasHigh = (sclLevel & ~sclRise) | sclFall;
    assign startDet   = sdaFall & sclWasHigh;
    assign stopDet    = sdaRise & sclWasHigh;
    assign byteDone   = (bitCnt_q == CNT_FULL);
    assign rxByte     = {shift_q[BYTE_W-2:0], sdaLevel};

    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        oe_d     = oe_q;
        busy_d   = busy_q;
        stop_d   = 1'b0;
        rw_d     = rw_q;

        if (startDet) begin
            state_d  = ST_ADDR;
            bitCnt_d = '0;
            oe_d     = 1'b0;
        end else if (stopDet) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            stop_d  = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (sclRise && !byteDone) begin
                        shift_d  = rxByte;
                        bitCnt_d = bitCnt_q + 4'd1;
                    end else if (sclFall && byteDone) begin
                        bitCnt_d = '0;
                        if (shift_q[BYTE_W-1:1] == DEV_ADDR) begin
                            oe_d    = 1'b1;
                            busy_d  = 1'b1;
                            rw_d    = shift_q[0];
                            state_d = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (sclFall) begin
                        oe_d     = 1'b0;
                        bitCnt_d = '0;
                        if (!rw_q) begin
                            state_d = ST_PTR;
                        end else begin
                            shift_d  = iREG_RDATA;
                            oe_d     = ~iREG_RDATA[BYTE_W-1];
                            bitCnt_d = 4'd1;
                            state_d  = ST_RDATA;
                        end
                    end
                end
                ST_PTR: begin
                    if (sclRise && !byteDone) begin
                        shift_d  = rxByte;
                        bitCnt_d = bitCnt_q + 4'd1;
                        if (bitCnt_q == CNT_FULL - 4'd1) begin
                            ptr_d = rxByte;
                        end
                    end else if (sclFall && byteDone) begin
                        oe_d     = 1'b1;
                        bitCnt_d = '0;
                        state_d  = ST_PTR_ACK;
                    end
                end
                ST_PTR_ACK: begin
                    if (sclFall) begin
                        oe_d     = 1'b0;
                        bitCnt_d = '0;
                        state_d  = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (sclRise && !byteDone) begin
                        shift_d  = rxByte;
                        bitCnt_d = bitCnt_q + 4'd1;
                        if (bitCnt_q == CNT_FULL - 4'd1) begin
                            wdata_d = rxByte;
                            we_d    = 1'b1;
                        end
                    end else if (sclFall && byteDone) begin
                        oe_d     = 1'b1;
                        bitCnt_d = '0;
                        state_d  = ST_WDATA_ACK;
                    end
                end
                ST_WDATA_ACK: begin
                    if (sclFall) begin
                        oe_d    = 1'b0;
                        ptr_d   = ptr_q + 8'd1;
                        state_d = ST_WDATA;
                    end
                end
                // bitCnt counts bits already placed on the bus; the MSB went out on entry.
                ST_RDATA: begin
                    if (sclFall) begin
                        if (byteDone) begin
                            oe_d     = 1'b0;
                            bitCnt_d = '0;
                            state_d  = ST_RDATA_MACK;
                        end else begin
                            oe_d     = ~shift_q[BYTE_W-2];
                            shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
                            bitCnt_d = bitCnt_q + 4'd1;
                        end
                    end
                end
                // The pointer advances past every byte read, acknowledged or not.
                ST_RDATA_MACK: begin
                    if (sclRise) begin
                        ptr_d = ptr_q + 8'd1;
                        if (sdaLevel == I2C_NACK) begin
                            state_d = ST_IGNORE;
                        end
                    end else if (sclFall) begin
                        shift_d  = iREG_RDATA;
                        oe_d     = ~iREG_RDATA[BYTE_W-1];
                        bitCnt_d = 4'd1;
                        state_d  = ST_RDATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= ST_IDLE;
            bitCnt_q <= '0;
            shift_q  <= '0;
            ptr_q    <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            stop_q   <= 1'b0;
            rw_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            stop_q   <= stop_d;
            rw_q     <= rw_d;
        end
    end

    assign oSDA_OE    = oe_q;
    assign oREG_ADDR  = ptr_q;
    assign oREG_WDATA = wdata_q;
    assign oREG_WE    = we_q;
    assign oBUSY      = busy_q;
    assign oSTOP      = stop_q;

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (responder) with an 8-bit register pointer and an external byte register port; the counterpart of the HDMI I2C configuration initiator.
- Uses: loopback verification of the HDMI config sequence, and exposing fabric status/control registers to an external or HPS I2C master.
- Oversamples SCL/SDA on the system clock. Never stretches SCL. Drives SDA open-drain through an output-enable.

Parameters:
- DEV_ADDR, 7'h39, 7-bit target address matched after START.
- SYNC_STAGES, 2, synchronizer flops per line.
- FILT_LEN, 3, consecutive equal samples required before a filtered line changes.

Ports:
- iCLK  input  1  system clock, 50 MHz.
- iRST_N  input  1  asynchronous active-low reset.
- I2C_SCLK  input  1  bus clock, input only.
- I2C_SDAT_IN  input  1  bus data sampled from the pad.
- oSDA_OE  output  1  1 = pull SDA low; 0 = release.
- oREG_ADDR  output  8  current register pointer.
- oREG_WDATA  output  8  last received write byte.
- oREG_WE  output  1  one-cycle write strobe.
- iREG_RDATA  input  8  read data for oREG_ADDR; combinational or registered, and valid within 2 iCLK of the address.
- oBUSY  output  1  high from an addressed START until STOP.
- oSTOP  output  1  one-cycle pulse on every detected STOP.

Behaviour:
- Reset: all outputs 0, state IDLE, pointer 0x00.
- Assertion of iRST_N releases oSDA_OE asynchronously, including mid-transfer.
- Input conditioning: each line passes through SYNC_STAGES flops, then the FILT_LEN glitch filter. Edges are detected on the filtered signals.
  - Total input latency is SYNC_STAGES+FILT_LEN iCLK.
  - Operation is required for SCL ≤ 400 kHz with iCLK = 50 MHz.
- START is an SDA fall while SCL is high. STOP is an SDA rise while SCL is high. Both are recognised in every state.
  - START (including repeated START) goes to ADDR and clears the bit counter.
  - STOP goes to IDLE, releases SDA, clears oBUSY and pulses oSTOP.
- Bit transfer:
  - Data is sampled on filtered SCL rise.
  - oSDA_OE changes only on filtered SCL fall, except for reset, START and STOP.
  - Bytes are MSB first.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK, IGNORE.
- ADDR: shift 8 bits.
  - Bits[7:1] == DEV_ADDR: on the following SCL fall, assert OE (ACK) and enter ADDR_ACK; set oBUSY.
  - Mismatch: no ACK, enter IGNORE until START/STOP.
- ADDR_ACK: on the next SCL fall, release OE.
  - R/W = 0: go to PTR.
  - R/W = 1: load iREG_RDATA into the shift register, drive the MSB (OE = ~bit), go to RDATA.
- PTR: 8 bits load the pointer onto oREG_ADDR. Always ACK (PTR_ACK), then go to WDATA.
- WDATA: on the 8th-bit SCL rise, set oREG_WDATA and pulse oREG_WE for one iCLK. ACK the byte.
  - At the end of the ACK bit, the pointer increments (0xFF wraps to 0x00).
  - Further bytes repeat WDATA.
- RDATA: shift out 8 bits, releasing OE after bit 0, then go to RDATA_MACK.
  - Master ACK (SDA low at SCL rise): pointer increments and wraps. On the following SCL fall, reload from iREG_RDATA with the new pointer, then drive the MSB.
  - Master NACK: release, enter IGNORE.
- Simultaneous START/STOP and a bit edge in the same iCLK: START/STOP has priority.
- A START during WDATA before the 8th bit discards the partial byte with no strobe.

Decomposition:
- Package i2c_tgt_pkg holds:
  - the state enum;
  - I2C_ACK = 1'b0 and I2C_NACK = 1'b1;
  - BYTE_W = 8.
- Sub-module i2c_line_filter (synchronizer + glitch filter + rise/fall pulses) is instantiated once for SCL and once for SDA.

Test Plan:
- Write burst: S, 0x72, 0x10, 0xAB, 0xCD, P → ACK on all 4 bytes. oREG_WE pulses twice: WDATA 0xAB at addr 0x10, then 0xCD at addr 0x11. oSTOP pulses; oBUSY ends at 0.
- Random read with repeated start: S, 0x72, 0x05, Sr, 0x73, then reads with model RDATA = addr ^ 0x5A and ACK, NACK, P → bytes 0x5F, 0x5C; pointer ends at 0x07.
- Address mismatch: S, 0x74, 0x00, P → SDA never driven, oREG_WE never asserted, oBUSY stays 0, oSTOP pulses.
- Pointer wrap: write to 0xFF with 2 data bytes → strobes at 0xFF then 0x00.
- Glitch and reset: a 2-iCLK SDA pulse while SCL is high is ignored (no START/STOP). iRST_N is asserted during the RDATA bit-3 drive → oSDA_OE is 0 in the same cycle and the state is IDLE after release.
- START abort: S, 0x72, 0x20, then 4 data bits, then Sr → no oREG_WE, and FSM is in ADDR.
